// File: rtl/irq_ctrl_pkg.sv
// Shared register offsets and the byte-lane merge helper for the interrupt controller.
package irq_ctrl_pkg;

  localparam logic [3:0] IRQ_PENDING = 4'h0;
  localparam logic [3:0] IRQ_MASK    = 4'h4;
  localparam logic [3:0] IRQ_MODE    = 4'h8;
  localparam logic [3:0] IRQ_ID      = 4'hC;

  function automatic logic [31:0] byte_merge(input logic [31:0] old,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = wdata[8*b +: 8];
    return r;
  endfunction

endpackage

// File: rtl/irq_sync.sv
// Two-flop synchroniser for asynchronous interrupt lines.
module irq_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/irq_controller.sv
// N_IRQ-channel interrupt controller: sync, edge/level pending, mask, priority ID,
// all reachable over the byte-enabled register bus.
module irq_controller
  import irq_ctrl_pkg::*;
#(
  parameter int N_IRQ = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic [3:0]       addr,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic [N_IRQ-1:0] hwint,
  output logic             irq
);

  logic [N_IRQ-1:0] s, s_d, pending, mask, mode;
  logic [N_IRQ-1:0] mask_nx, mode_nx, clr, rise, pend_nx;
  logic [5:0]       id;
  logic             unused_addr_lsb;

  assign unused_addr_lsb = ^addr[1:0];

  irq_sync #(.W(N_IRQ)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (irq_in),
    .q     (s)
  );

  assign rise = s & ~s_d;

  always_comb begin
    mask_nx = mask;
    mode_nx = mode;
    clr     = '0;
    if (we) begin
      case (addr[3:2])
        IRQ_MASK[3:2]:    mask_nx = N_IRQ'(byte_merge(32'(mask), wdata, be));
        IRQ_MODE[3:2]:    mode_nx = N_IRQ'(byte_merge(32'(mode), wdata, be));
        IRQ_PENDING[3:2]: clr     = N_IRQ'(byte_merge('0, wdata, be)) & mode;
        default: ;
      endcase
    end
    // Level bits track s; bits staying edge keep sticky state (set beats W1C);
    // bits just switched to edge start cleared so a held-high level never fires.
    pend_nx = (~mode_nx & s) | (mode_nx & mode & ((pending & ~clr) | rise));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_d     <= '0;
      pending <= '0;
      mask    <= '0;
      mode    <= '0;
    end else begin
      s_d     <= s;
      pending <= pend_nx;
      mask    <= mask_nx;
      mode    <= mode_nx;
    end
  end

  assign hwint = pending & mask;
  assign irq   = |hwint;

  always_comb begin
    id = 6'(N_IRQ);
    for (int i = N_IRQ - 1; i >= 0; i--)
      if (hwint[i]) id = 6'(i);
  end

  always_comb begin
    case (addr[3:2])
      IRQ_PENDING[3:2]: rdata = 32'(pending);
      IRQ_MASK[3:2]:    rdata = 32'(mask);
      IRQ_MODE[3:2]:    rdata = 32'(mode);
      default:          rdata = 32'(id);
    endcase
  end

endmodule
